// File: rtl/arbitro_enrutamiento_param.sv
// rtl/arbitro_enrutamiento_param.sv - NUM_VC-to-NUM_DEST routing arbiter, 2-stage pop/route pipeline
// Optional rotating priority when ROUND_ROBIN_EN is defined; strict lowest-index priority otherwise.
module arbitro_enrutamiento_param #(
    parameter int DATA_W   = 6,
    parameter int NUM_VC   = 2,
    parameter int NUM_DEST = 2,
    parameter int DEST_LSB = 4
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic [NUM_VC*DATA_W-1:0]   VC_data,
    input  logic [NUM_VC-1:0]          VC_empty,
    input  logic [NUM_DEST-1:0]        D_pause,
    output logic [NUM_VC-1:0]          VC_pop,
    output logic [NUM_DEST-1:0]        D_push,
    output logic [NUM_DEST*DATA_W-1:0] D_out,
    output logic                       drop_err,
    output logic                       idle
);
    localparam int DEST_W = $clog2(NUM_DEST);
    localparam int IDX_W  = $clog2(NUM_VC);

    logic                       pop_vld_q, pop_vld_d;
    logic [IDX_W-1:0]           pop_idx_q, pop_idx_d;
    logic [NUM_DEST-1:0]        d_push_q, d_push_d;
    logic [NUM_DEST*DATA_W-1:0] d_out_q, d_out_d;
    logic                       drop_err_q, drop_err_d;

    logic                       found;
    logic [IDX_W-1:0]           winner;
    logic                       pop_fire;
    logic [NUM_VC-1:0]          vc_pop;
    logic [DATA_W-1:0]          word;
    logic [DEST_W-1:0]          dest;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0]           ptr_q, ptr_d;

    // Search begins at the grant pointer and wraps around the VC set.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            if (!found && !VC_empty[(int'(ptr_q) + k) % NUM_VC]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(ptr_q) + k) % NUM_VC);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (pop_fire) begin
            ptr_d = (int'(winner) == NUM_VC - 1) ? '0 : IDX_W'(int'(winner) + 1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (!VC_empty[k]) begin
                found  = 1'b1;
                winner = IDX_W'(k);
            end
        end
    end
`endif

    // Any pause stalls every VC; the pause threshold absorbs the two words already in flight.
    always_comb begin
        pop_fire = reset_L & ~(|D_pause) & found;
        vc_pop   = '0;
        if (pop_fire) begin
            vc_pop[winner] = 1'b1;
        end
    end

    always_comb begin
        pop_vld_d  = pop_fire;
        pop_idx_d  = winner;
        d_push_d   = '0;
        d_out_d    = d_out_q;
        drop_err_d = 1'b0;
        word       = VC_data[pop_idx_q*DATA_W +: DATA_W];
        dest       = word[DEST_LSB +: DEST_W];
        if (pop_vld_q) begin
            if (int'(dest) < NUM_DEST) begin
                d_push_d[dest]                         = 1'b1;
                d_out_d[int'(dest)*DATA_W +: DATA_W]   = word;
            end else begin
                drop_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_vld_q  <= 1'b0;
            pop_idx_q  <= '0;
            d_push_q   <= '0;
            d_out_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            pop_vld_q  <= pop_vld_d;
            pop_idx_q  <= pop_idx_d;
            d_push_q   <= d_push_d;
            d_out_q    <= d_out_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign VC_pop   = vc_pop;
    assign D_push   = d_push_q;
    assign D_out    = d_out_q;
    assign drop_err = drop_err_q;
    assign idle     = ~(|vc_pop) & ~pop_vld_q & ~(|d_push_q);

endmodule

// File: tb/tb_arbitro_enrutamiento_param.sv
// tb/tb_arbitro_enrutamiento_param.sv - randomized bench with a queue-based reference model
module tb_arbitro_enrutamiento_param;
    localparam int DATA_W   = 6;
    localparam int NUM_VC   = 2;
    localparam int NUM_DEST = 3;
    localparam int DEST_LSB = 4;
    localparam int DEST_W   = 2;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset_L;
    logic [NUM_VC*DATA_W-1:0]   VC_data;
    logic [NUM_VC-1:0]          VC_empty;
    logic [NUM_DEST-1:0]        D_pause;
    logic [NUM_VC-1:0]          VC_pop;
    logic [NUM_DEST-1:0]        D_push;
    logic [NUM_DEST*DATA_W-1:0] D_out;
    logic                       drop_err;
    logic                       idle;

    arbitro_enrutamiento_param #(
        .DATA_W(DATA_W), .NUM_VC(NUM_VC), .NUM_DEST(NUM_DEST), .DEST_LSB(DEST_LSB)
    ) dut (
        .clk(clk), .reset_L(reset_L), .VC_data(VC_data), .VC_empty(VC_empty),
        .D_pause(D_pause), .VC_pop(VC_pop), .D_push(D_push), .D_out(D_out),
        .drop_err(drop_err), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                v;
        int                vc;
        logic [DATA_W-1:0] w;
    } ev_t;

    logic [DATA_W-1:0] q [NUM_VC][$];
    logic [DATA_W-1:0] mdout [NUM_DEST];
    ev_t s1, s2;
    int  rr_p;
    int  checks;
    int  errors;

    // One clock of the reference model: s2 is the pop decided two cycles ago, s1 the one decided last cycle.
    task automatic run_cycle(input logic [NUM_DEST-1:0] pause, input logic rst_v);
        logic [NUM_DEST-1:0]        e_push;
        logic                       e_drop;
        logic                       e_idle;
        logic [NUM_VC-1:0]          e_pop;
        logic [NUM_DEST*DATA_W-1:0] e_out;
        logic [DEST_W-1:0]          d;
        ev_t                        cur;
        int                         c;
        @(negedge clk);
        e_push = '0;
        e_drop = 1'b0;
        if (reset_L && s2.v) begin
            d = s2.w[DEST_LSB +: DEST_W];
            if (d < NUM_DEST) begin
                e_push[d] = 1'b1;
                mdout[d]  = s2.w;
            end else begin
                e_drop = 1'b1;
            end
        end
        if (reset_L && s1.v) VC_data[s1.vc*DATA_W +: DATA_W] = s1.w;
        reset_L = rst_v;
        D_pause = pause;
        for (int i = 0; i < NUM_VC; i++) VC_empty[i] = (q[i].size() == 0);
        cur.v = 1'b0; cur.vc = 0; cur.w = '0;
        if (rst_v && pause == '0) begin
            for (int k = 0; k < NUM_VC; k++) begin
                c = RR ? (rr_p + k) % NUM_VC : k;
                if (!cur.v && q[c].size() != 0) begin
                    cur.v  = 1'b1;
                    cur.vc = c;
                end
            end
            if (cur.v) begin
                cur.w = q[cur.vc].pop_front();
                if (RR) rr_p = (cur.vc + 1) % NUM_VC;
            end
        end
        e_pop = '0;
        if (cur.v) e_pop[cur.vc] = 1'b1;
        for (int j = 0; j < NUM_DEST; j++) e_out[j*DATA_W +: DATA_W] = mdout[j];
        e_idle = !cur.v && !s1.v && (e_push == '0);
        #1;
        checks += 5;
        if (VC_pop !== e_pop) begin errors++; $display("FAIL model_vc_pop t=%0t got %b exp %b", $time, VC_pop, e_pop); end
        if (D_push !== e_push) begin errors++; $display("FAIL model_d_push t=%0t got %b exp %b", $time, D_push, e_push); end
        if (D_out !== e_out) begin errors++; $display("FAIL model_d_out t=%0t got %h exp %h", $time, D_out, e_out); end
        if (drop_err !== e_drop) begin errors++; $display("FAIL model_drop_err t=%0t got %b exp %b", $time, drop_err, e_drop); end
        if (idle !== e_idle) begin errors++; $display("FAIL model_idle t=%0t got %b exp %b", $time, idle, e_idle); end
        s2 = s1;
        s1 = cur;
    endtask

    // Asserts reset between edges; the word chosen for the coming edge was never really popped.
    task automatic assert_reset_async();
        #2 reset_L = 1'b0;
        #1;
        if (s1.v) q[s1.vc].push_front(s1.w);
        s1.v = 1'b0;
        s2.v = 1'b0;
        rr_p = 0;
        for (int j = 0; j < NUM_DEST; j++) mdout[j] = '0;
        checks++;
        if (VC_pop !== '0 || D_push !== '0 || D_out !== '0 || idle !== 1'b1 || drop_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset pop=%b push=%b out=%h idle=%b drop=%b exp 0/0/0/1/0",
                     VC_pop, D_push, D_out, idle, drop_err);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0 || s1.v || s2.v) && n < 64) begin
            run_cycle('0, 1'b1);
            n++;
        end
        checks++;
        if (n >= 64) begin errors++; $display("FAIL drain_timeout got %0d cycles exp <64", n); end
    endtask

    task automatic test_reset();
        reset_L  = 1'b0;
        VC_empty = '0;
        D_pause  = '0;
        VC_data  = '0;
        s1.v = 1'b0; s2.v = 1'b0; rr_p = 0;
        for (int j = 0; j < NUM_DEST; j++) mdout[j] = '0;
        #2;
        checks++;
        if (VC_pop !== '0 || D_push !== '0 || D_out !== '0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_state pop=%b push=%b out=%h idle=%b exp 0/0/0/1", VC_pop, D_push, D_out, idle);
        end
        for (int i = 0; i < NUM_VC; i++) repeat (3) q[i].push_back(6'($urandom_range(0, 47)));
        run_cycle('0, 1'b0);
        run_cycle('0, 1'b0);
        checks++;
        if (VC_pop !== '0) begin errors++; $display("FAIL reset_no_pop got %b exp 00", VC_pop); end
        drain();
    endtask

    task automatic test_routing();
        q[0].push_back(6'h12);
        run_cycle('0, 1'b1);
        checks++;
        if (VC_pop !== 2'b01) begin errors++; $display("FAIL route_pop0 got %b exp 01", VC_pop); end
        run_cycle('0, 1'b1);
        run_cycle('0, 1'b1);
        checks++;
        if (D_push !== 3'b010 || D_out[11:6] !== 6'h12) begin
            errors++; $display("FAIL route_12 push=%b out=%h exp 010/12", D_push, D_out[11:6]);
        end
        q[1].push_back(6'h05);
        run_cycle('0, 1'b1);
        checks++;
        if (VC_pop !== 2'b10) begin errors++; $display("FAIL route_pop1 got %b exp 10", VC_pop); end
        run_cycle('0, 1'b1);
        run_cycle('0, 1'b1);
        checks++;
        if (D_push !== 3'b001 || D_out[5:0] !== 6'h05) begin
            errors++; $display("FAIL route_05 push=%b out=%h exp 001/05", D_push, D_out[5:0]);
        end
        drain();
    endtask

    task automatic test_pause();
        int pushes;
        for (int i = 0; i < 6; i++) q[0].push_back(6'($urandom_range(0, 47)));
        run_cycle('0, 1'b1);
        run_cycle('0, 1'b1);
        pushes = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(3'b001, 1'b1);
            checks++;
            if (VC_pop !== '0) begin errors++; $display("FAIL pause_pop cyc%0d got %b exp 00", i, VC_pop); end
            if (D_push != '0) pushes++;
        end
        checks++;
        if (pushes !== 2) begin errors++; $display("FAIL pause_inflight got %0d pushes exp 2", pushes); end
        run_cycle('0, 1'b1);
        checks++;
        if (VC_pop !== 2'b01) begin errors++; $display("FAIL pause_resume got %b exp 01", VC_pop); end
        drain();
    endtask

    task automatic test_priority();
        int p0;
        logic [NUM_VC-1:0] e;
        for (int i = 0; i < 4; i++) begin
            q[0].push_back(6'($urandom_range(0, 47)));
            q[1].push_back(6'($urandom_range(0, 47)));
        end
        p0 = rr_p;
        for (int i = 0; i < 8; i++) begin
            run_cycle('0, 1'b1);
            if (RR) e = ((p0 + i) % 2 == 0) ? 2'b01 : 2'b10;
            else    e = (i < 4) ? 2'b01 : 2'b10;
            checks++;
            if (VC_pop !== e) begin errors++; $display("FAIL priority_pop%0d got %b exp %b", i, VC_pop, e); end
        end
        drain();
    endtask

    task automatic test_illegal_dest();
        q[1].push_back(6'h35);
        run_cycle('0, 1'b1);
        run_cycle('0, 1'b1);
        run_cycle('0, 1'b1);
        checks++;
        if (drop_err !== 1'b1 || D_push !== '0) begin
            errors++; $display("FAIL illegal_drop drop=%b push=%b exp 1/000", drop_err, D_push);
        end
        run_cycle('0, 1'b1);
        checks++;
        if (drop_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse got %b exp 0", drop_err); end
        drain();
    endtask

    task automatic test_random();
        logic [NUM_DEST-1:0] p;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                int v;
                v = $urandom_range(0, NUM_VC - 1);
                if (q[v].size() < 8) q[v].push_back(6'($urandom));
            end
            p = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            run_cycle(p, 1'b1);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) q[0].push_back(6'($urandom_range(0, 47)));
        run_cycle('0, 1'b1);
        run_cycle('0, 1'b1);
        assert_reset_async();
        for (int i = 0; i < NUM_VC; i++) q[i].delete();
        run_cycle('0, 1'b0);
        run_cycle('0, 1'b0);
        run_cycle('0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_cycle('0, 1'b1);
            checks++;
            if (D_push !== '0 || idle !== 1'b1) begin
                errors++; $display("FAIL midreset_discard cyc%0d push=%b idle=%b exp 000/1", i, D_push, idle);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout t=%0t exp finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_routing();
        test_pause();
        test_priority();
        test_illegal_dest();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
